// File: rtl/port_rx_packet_mux.sv
// Per-channel packet buffers feeding one round-robin, whole-packet ready/valid output stream.
// Defining PORT_RX_STATS_EN adds pkt_count (per-channel commits) and the byte_overrun pulse.
module port_rx_packet_mux #(
    parameter int NCH = 2,
    parameter int CHW = 1,
    parameter int DW  = 8,
    parameter int AW  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] rx_word,
    input  logic [NCH-1:0]    rx_strobe,
    input  logic [NCH-1:0]    rx_complete,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_chan,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PORT_RX_STATS_EN
    output logic [NCH*16-1:0] pkt_count,
    output logic              byte_overrun,
`endif
    output logic [NCH*8-1:0]  drop_count
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_GRANT = 1'b1;
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [DW:0]    mem_r [NCH][DEPTH];
    logic [AW-1:0]  wr_ptr_r [NCH];
    logic [AW-1:0]  commit_ptr_r [NCH];
    logic [AW-1:0]  rd_ptr_r [NCH];
    logic [NCH-1:0] discard_r;
    logic [NCH-1:0] accept_s;
    logic [NCH-1:0] ovf_s;
    logic [NCH-1:0] pending_s;
    logic [0:0]     state_r;
    logic [CHW-1:0] grant_r;
    logic [CHW-1:0] rr_r;
    logic [CHW-1:0] sel_s;
    logic [CHW-1:0] idx_s;
    logic           any_pending_s;
    logic           load_s;
    logic [DW:0]    head_s;

    // Classify each strobe as stored byte or overflow; flag channels holding committed data
    always_comb begin
        accept_s  = '0;
        ovf_s     = '0;
        pending_s = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rx_strobe[c] && !discard_r[c]) begin
                if ((wr_ptr_r[c] + PTR_ONE) == rd_ptr_r[c]) begin
                    ovf_s[c] = 1'b1;
                end else begin
                    accept_s[c] = 1'b1;
                end
            end else begin
                accept_s[c] = 1'b0;
            end
            pending_s[c] = (commit_ptr_r[c] != rd_ptr_r[c]);
        end
    end

    // Buffer storage; entries are only meaningful between rd_ptr and wr_ptr, so no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (accept_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= {rx_complete[c], rx_word[c*DW +: DW]};
            end
        end
    end

    // Write pointers, commit pointers, discard mode and saturating drop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_r[c]     <= '0;
                commit_ptr_r[c] <= '0;
            end
            discard_r  <= '0;
            drop_count <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (accept_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + PTR_ONE;
                    if (rx_complete[c]) begin
                        commit_ptr_r[c] <= wr_ptr_r[c] + PTR_ONE;
                    end
                end else if (ovf_s[c]) begin
                    // Rewind so the partial packet vanishes; stay discarding unless this was its end
                    wr_ptr_r[c]  <= commit_ptr_r[c];
                    discard_r[c] <= !rx_complete[c];
                    if (drop_count[c*8 +: 8] != 8'hFF) begin
                        drop_count[c*8 +: 8] <= drop_count[c*8 +: 8] + 8'd1;
                    end
                end else if (rx_strobe[c] && rx_complete[c]) begin
                    discard_r[c] <= 1'b0;
                end
            end
        end
    end

`ifdef PORT_RX_STATS_EN
    // Committed-packet counters and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count    <= '0;
            byte_overrun <= 1'b0;
        end else begin
            byte_overrun <= |ovf_s;
            for (int c = 0; c < NCH; c++) begin
                if (accept_s[c] && rx_complete[c]) begin
                    pkt_count[c*16 +: 16] <= pkt_count[c*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

    // Round-robin search for the first channel with a committed packet at or after rr_r
    always_comb begin
        sel_s         = '0;
        idx_s         = '0;
        any_pending_s = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx_s = CHW'((int'(rr_r) + k) % NCH);
            if (!any_pending_s && pending_s[idx_s]) begin
                sel_s         = idx_s;
                any_pending_s = 1'b1;
            end else begin
                any_pending_s = any_pending_s;
            end
        end
    end

    assign head_s = mem_r[grant_r][rd_ptr_r[grant_r]];
    assign load_s = (state_r == ST_GRANT) && (!out_valid || out_ready);

    // Arbiter FSM, read pointers and registered output stage.
    // GRANT is left as soon as the last byte enters the output register, so the next
    // arbitration overlaps its handshake and packets are separated by a single idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            rr_r      <= '0;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr_r[c] <= '0;
            end
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load_s) begin
                out_data          <= head_s[DW-1:0];
                out_last          <= head_s[DW];
                out_chan          <= grant_r;
                out_valid         <= 1'b1;
                rd_ptr_r[grant_r] <= rd_ptr_r[grant_r] + PTR_ONE;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (any_pending_s) begin
                        state_r <= ST_GRANT;
                        grant_r <= sel_s;
                    end
                end
                ST_GRANT: begin
                    if (load_s && head_s[DW]) begin
                        state_r <= ST_IDLE;
                        rr_r    <= (grant_r == CHW'(NCH - 1)) ? '0 : grant_r + 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_rx_packet_mux.sv
// Scoreboard bench for port_rx_packet_mux: per-channel expected-byte queues filled by the
// stimulus, drained by an independent output monitor; directed cases plus random traffic.
module tb_port_rx_packet_mux;

    localparam int NCH    = 2;
    localparam int CHW    = 1;
    localparam int DW     = 8;
    localparam int AW     = 7;
    localparam int MAXPKT = (1 << AW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] rx_word = '0;
    logic [NCH-1:0]    rx_strobe = '0;
    logic [NCH-1:0]    rx_complete = '0;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_chan;
    logic              out_last;
    logic              out_valid;
    logic [NCH*8-1:0]  drop_count;
`ifdef PORT_RX_STATS_EN
    logic [NCH*16-1:0] pkt_count;
    logic              byte_overrun;
    int                ovr_cnt = 0;
`endif

    port_rx_packet_mux #(.NCH(NCH), .CHW(CHW), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_word     (rx_word),
        .rx_strobe   (rx_strobe),
        .rx_complete (rx_complete),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef PORT_RX_STATS_EN
        .pkt_count   (pkt_count),
        .byte_overrun(byte_overrun),
`endif
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         order_q[$];
    int         rdy_mode = 1;
    int         rise_cyc = -1;
    int         last_drive_cyc = 0;
    int         exp_drop[2] = '{0, 0};
    int         exp_pkt[2] = '{0, 0};
    int         exp_ovr = 0;

    function automatic void push(input int c, input logic [8:0] v);
        if (c == 0) q0.push_back(v);
        else q1.push_back(v);
        if (v[8]) exp_pkt[c]++;
    endfunction

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int sat8(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic [1:0] st, input logic [1:0] cp, input logic [15:0] w);
        rx_strobe      = st;
        rx_complete    = cp;
        rx_word        = w;
        last_drive_cyc = cyc;
        tick();
        rx_strobe   = 2'b00;
        rx_complete = 2'b00;
    endtask

    task automatic send_pkt(input int c, input int len, input bit deliver);
        logic [1:0]  st;
        logic [1:0]  cp;
        logic [15:0] w;
        logic [7:0]  b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            st = 2'b00; cp = 2'b00; w = 16'h0000;
            st[c] = 1'b1;
            cp[c] = (i == len - 1);
            w[c*8 +: 8] = b;
            if (deliver) push(c, {cp[c], b});
            drive(st, cp, w);
        end
    endtask

    // Model rule: a packet survives only if it fits in the space left after occ stored bytes
    task automatic send_model(input int c, input int len, input int occ);
        bit deliver;
        deliver = (occ + len) <= MAXPKT;
        if (!deliver) begin
            exp_drop[c]++;
            exp_ovr++;
        end
        send_pkt(c, len, deliver);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: drain timeout, %0d bytes still expected", name, q0.size() + q1.size());
        end
        repeat (3) tick();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: out_valid never rose, got 0 want 1", name);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

`ifdef PORT_RX_STATS_EN
    initial begin
        forever begin
            @(negedge clk);
            if (rst) ovr_cnt = 0;
            else if (byte_overrun) ovr_cnt++;
        end
    end
`endif

    // Output monitor: pops the scoreboard on every handshake and checks AXI-stream hold rules
    logic [7:0] prev_data;
    logic       prev_last;
    logic       prev_chan;
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    bit         in_pkt = 1'b0;
    logic       pkt_chan = 1'b0;
    initial begin
        logic [8:0] exp_v;
        bit         empty;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
                in_pkt     = 1'b0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (!out_valid || out_data != prev_data || out_last != prev_last || out_chan != prev_chan) begin
                        bad++;
                        $display("FAIL stall_hold: got v=%0b d=%02h l=%0b c=%0d want v=1 d=%02h l=%0b c=%0d",
                                 out_valid, out_data, out_last, out_chan, prev_data, prev_last, prev_chan);
                    end
                end
                if (out_valid && !prev_valid) rise_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (in_pkt) begin
                        total++;
                        if (out_chan != pkt_chan) begin
                            bad++;
                            $display("FAIL interleave: got chan %0d want chan %0d", out_chan, pkt_chan);
                        end
                    end
                    empty = (out_chan == 1'b0) ? (q0.size() == 0) : (q1.size() == 0);
                    total++;
                    if (empty) begin
                        bad++;
                        $display("FAIL unexpected_byte ch%0d: got %03h want nothing", out_chan, {out_last, out_data});
                    end else begin
                        exp_v = (out_chan == 1'b0) ? q0.pop_front() : q1.pop_front();
                        if ({out_last, out_data} != exp_v) begin
                            bad++;
                            $display("FAIL byte ch%0d: got %03h want %03h", out_chan, {out_last, out_data}, exp_v);
                        end
                    end
                    if (out_last) begin
                        order_q.push_back(int'(out_chan));
                        in_pkt = 1'b0;
                    end else begin
                        in_pkt   = 1'b1;
                        pkt_chan = out_chan;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_valid = out_valid;
                prev_data  = out_data;
                prev_last  = out_last;
                prev_chan  = out_chan;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rem[2];
        int          len;
        logic [1:0]  st;
        logic [1:0]  cp;
        logic [15:0] w;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_last", int'(out_last), 0);
        check("reset_data", int'(out_data), 0);
        check("reset_chan", int'(out_chan), 0);
        check("reset_drop", int'(drop_count), 0);
        tick();

        // Two packets per channel, committed in the same cycles on both channels
        order_q.delete();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b0;
            logic [7:0] b1;
            logic       l;
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            l  = (i == 2) || (i == 5);
            push(0, {l, b0});
            push(1, {l, b1});
            drive(2'b11, {l, l}, {b1, b0});
        end
        wait_drain("dual_commit", 200);
        check("rr_order_len", order_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < order_q.size()) check($sformatf("rr_order_%0d", k), order_q[k], k % 2);
        end

        // Latency of a 3-byte packet into an idle arbiter
        rise_cyc = -1;
        order_q.delete();
        push(0, 9'h011); drive(2'b01, 2'b00, 16'h0011);
        push(0, 9'h022); drive(2'b01, 2'b00, 16'h0022);
        push(0, 9'h133); drive(2'b01, 2'b01, 16'h0033);
        wait_drain("three_byte", 100);
        check("latency", rise_cyc - last_drive_cyc, 3);
        check("three_byte_chan", (order_q.size() == 1) ? order_q[0] : -1, 0);

        // Oversized packet on ch1 is dropped; the following short packet survives
        send_model(1, MAXPKT + 13, 0);
        send_model(1, 4, 0);
        wait_drain("overflow", 200);
        check("drop_ch1", int'(drop_count[15:8]), sat8(exp_drop[1]));
        check("drop_ch0", int'(drop_count[7:0]), sat8(exp_drop[0]));

        // 64-byte packet with 50% random back-pressure
        rdy_mode = 2;
        send_model(0, 64, 0);
        wait_drain("stall64", 2000);

        // Random concurrent traffic on both channels
        rem = '{0, 0};
        for (int t = 0; t < 800; t++) begin
            st = 2'b00; cp = 2'b00; w = 16'h0000;
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0 && t < 700 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 16);
                    if (qsize(c) + len <= 100) rem[c] = len;
                end
                if (rem[c] != 0 && $urandom_range(0, 3) != 0) begin
                    st[c] = 1'b1;
                    cp[c] = (rem[c] == 1);
                    w[c*8 +: 8] = 8'($urandom);
                    rem[c]--;
                    push(c, {cp[c], w[c*8 +: 8]});
                end
            end
            drive(st, cp, w);
        end
        wait_drain("random", 3000);
        rdy_mode = 1;

        // Stalled ch0 holds a big committed packet; every short packet after it overflows
        rdy_mode = 0;
        tick();
        send_model(0, 120, 0);
        wait_valid("sat_first_byte", 20);
        for (int i = 0; i < 260; i++) send_model(0, 10, 119);
        check("drop_sat_ch0", int'(drop_count[7:0]), sat8(exp_drop[0]));
        check("drop_keep_ch1", int'(drop_count[15:8]), sat8(exp_drop[1]));
`ifdef PORT_RX_STATS_EN
        check("pkt_count_ch0", int'(pkt_count[15:0]), exp_pkt[0]);
        check("pkt_count_ch1", int'(pkt_count[31:16]), exp_pkt[1]);
        check("overrun_pulses", ovr_cnt, exp_ovr);
`endif
        rdy_mode = 1;
        wait_drain("sat_release", 500);

        // Reset while ch1 is mid-output and ch0 is mid-packet
        rdy_mode = 0;
        tick();
        send_pkt(1, 30, 1'b1);
        wait_valid("rst_mid_output", 20);
        for (int i = 0; i < 5; i++) drive(2'b01, 2'b00, {8'h00, 8'($urandom)});
        rst = 1'b1;
        drive(2'b01, 2'b00, 16'h00AA);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        order_q.delete();
        exp_drop = '{0, 0};
        exp_pkt  = '{0, 0};
        exp_ovr  = 0;
        @(negedge clk);
        check("rst2_valid", int'(out_valid), 0);
        check("rst2_last", int'(out_last), 0);
        check("rst2_data", int'(out_data), 0);
        check("rst2_chan", int'(out_chan), 0);
        check("rst2_drop", int'(drop_count), 0);
        rdy_mode = 1;
        tick();
        send_model(0, 6, 0);
        send_model(1, 4, 0);
        wait_drain("after_reset", 200);
        check("after_reset_pkts", order_q.size(), 2);
`ifdef PORT_RX_STATS_EN
        check("after_reset_cnt0", int'(pkt_count[15:0]), exp_pkt[0]);
        check("after_reset_cnt1", int'(pkt_count[31:16]), exp_pkt[1]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
